// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between a router port and a host
// port. An owner keeps the SRAM for as long as its chip select stays high;
// grants are combinational so an accepted access reaches the SRAM in the
// same cycle. Read data comes back one cycle later and is steered to the
// port that issued the read.
// Optional feature: define ARB_ROUND_ROBIN_EN to break simultaneous
// requests in favour of the port that was not served last. By default the
// router always wins ties.
module sram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r_cs,
  input  logic                  r_we,
  input  logic [ADDR_WIDTH-1:0] r_address,
  input  logic [DATA_WIDTH-1:0] r_wdata,
  output logic [DATA_WIDTH-1:0] r_rdata,
  input  logic                  h_cs,
  input  logic                  h_we,
  input  logic [ADDR_WIDTH-1:0] h_address,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  output logic                  h_gnt,
  output logic                  r_gnt,
  output logic [DATA_WIDTH-1:0] h_rdata,
  output logic                  h_rvalid,
  output logic                  m_cs,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic [15:0]           r_count,
  output logic [15:0]           h_count
);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_ROUTER = 2'd1,
    OWN_HOST   = 2'd2
  } owner_t;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  owner_t owner;
  owner_t last_served;
  owner_t rd_src;
  owner_t winner;
  owner_t eff;

  // Pick a winner among the current requesters, ignoring any lock.
  always_comb begin
    winner = OWN_NONE;
    if (r_cs && h_cs) begin
      winner = (RR_EN && last_served == OWN_ROUTER) ? OWN_HOST : OWN_ROUTER;
    end else if (r_cs) begin
      winner = OWN_ROUTER;
    end else if (h_cs) begin
      winner = OWN_HOST;
    end
  end

  // Effective owner: a locked owner keeps the SRAM while its cs stays high;
  // reset forces the SRAM idle immediately, dropping any lock.
  always_comb begin
    eff = winner;
    if (reset) begin
      eff = OWN_NONE;
    end else if (owner == OWN_ROUTER && r_cs) begin
      eff = OWN_ROUTER;
    end else if (owner == OWN_HOST && h_cs) begin
      eff = OWN_HOST;
    end
  end

  assign r_gnt = (eff == OWN_ROUTER);
  assign h_gnt = (eff == OWN_HOST);
  assign m_cs  = (r_cs & r_gnt) | (h_cs & h_gnt);

  // Steer the granted port's command onto the SRAM; drive zeros when idle.
  always_comb begin
    m_we      = 1'b0;
    m_address = '0;
    m_wdata   = '0;
    case (eff)
      OWN_ROUTER: begin
        m_we      = r_we;
        m_address = r_address;
        m_wdata   = r_wdata;
      end
      OWN_HOST: begin
        m_we      = h_we;
        m_address = h_address;
        m_wdata   = h_wdata;
      end
      default: begin
        m_we      = 1'b0;
        m_address = '0;
        m_wdata   = '0;
      end
    endcase
  end

  // The router samples read data without a qualifier; the host gets a valid.
  assign h_rvalid = !reset && (rd_src == OWN_HOST);
  assign h_rdata  = h_rvalid ? m_rdata : '0;
  assign r_rdata  = m_rdata;

  // Ownership, fairness history, read steering and saturating grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= OWN_NONE;
      last_served <= OWN_HOST;
      rd_src      <= OWN_NONE;
      r_count     <= 16'd0;
      h_count     <= 16'd0;
    end else begin
      owner <= eff;
      if (eff != OWN_NONE) begin
        last_served <= eff;
      end
      rd_src <= (m_cs && !m_we) ? eff : OWN_NONE;
      if (r_gnt && r_cs && r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
      end
      if (h_gnt && h_cs && h_count != 16'hFFFF) begin
        h_count <= h_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scoreboard bench for sram_arbiter. Stimulus pushes
// the expected SRAM accesses and read returns into queues; a monitor pops and
// compares whenever the SRAM is accessed or read data is presented.
// Build with or without ARB_ROUND_ROBIN_EN; tie-break expectations follow it.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r_cs, r_we, h_cs, h_we;
  logic [7:0]  r_address, r_wdata, h_address, h_wdata;
  logic [7:0]  r_rdata, h_rdata, m_address, m_wdata, m_rdata;
  logic        h_gnt, r_gnt, h_rvalid, m_cs, m_we;
  logic [15:0] r_count, h_count;

  typedef struct packed {
    logic       router;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } access_t;

  access_t    acc_q[$];
  logic [7:0] rrd_q[$];
  logic [7:0] hrd_q[$];

  int num_checks = 0;
  int num_errors = 0;

  logic [7:0] mem [256];
  logic       rr_pending = 1'b0;

  sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .r_cs(r_cs), .r_we(r_we), .r_address(r_address), .r_wdata(r_wdata),
    .r_rdata(r_rdata),
    .h_cs(h_cs), .h_we(h_we), .h_address(h_address), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .r_gnt(r_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .m_cs(m_cs), .m_we(m_we), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .r_count(r_count), .h_count(h_count)
  );

  always #5 clk = ~clk;

  // Simple SRAM model: one-cycle read latency, preloaded on reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h05] <= 8'hA5;
      mem[8'h10] <= 8'hEE;
    end else if (m_cs && m_we) begin
      mem[m_address] <= m_wdata;
    end
    m_rdata <= (m_cs && !m_we) ? mem[m_address] : 8'h00;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic report_unexpected(input string name);
    num_checks++;
    num_errors++;
    $display("[TB] FAIL %s: DUT presented output with nothing expected at %0t", name, $time);
  endtask

  task automatic apply_stimulus(input logic rst,
                                input logic rcs, input logic rwe,
                                input logic [7:0] raddr, input logic [7:0] rwd,
                                input logic hcs, input logic hwe,
                                input logic [7:0] haddr, input logic [7:0] hwd);
    @(posedge clk);
    #1;
    reset = rst;
    r_cs = rcs; r_we = rwe; r_address = raddr; r_wdata = rwd;
    h_cs = hcs; h_we = hwe; h_address = haddr; h_wdata = hwd;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic expect_access(input logic router, input logic we,
                               input logic [7:0] addr, input logic [7:0] wdata);
    access_t a;
    a.router = router; a.we = we; a.addr = addr; a.wdata = wdata;
    acc_q.push_back(a);
  endtask

  // Memory contents as seen by reads in this directed sequence.
  function automatic logic [7:0] exp_mem(input logic [7:0] addr);
    case (addr)
      8'h05:   return 8'hA5;
      8'h10:   return 8'hEE;
      8'h80:   return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: compare SRAM accesses and returned read data against the queues.
  always @(negedge clk) begin
    access_t e;
    if (rr_pending) begin
      if (rrd_q.size() == 0) report_unexpected("r_rdata");
      else check_output("r_rdata", {24'd0, r_rdata}, {24'd0, rrd_q.pop_front()});
    end
    rr_pending = 1'b0;
    if (h_rvalid) begin
      if (hrd_q.size() == 0) report_unexpected("h_rvalid");
      else check_output("h_rdata", {24'd0, h_rdata}, {24'd0, hrd_q.pop_front()});
    end
    if (m_cs) begin
      if (acc_q.size() == 0) begin
        report_unexpected("m_cs");
      end else begin
        e = acc_q.pop_front();
        check_output("access", {13'd0, r_gnt, h_gnt, m_we, m_address, m_wdata},
                     {13'd0, e.router, !e.router, e.we, e.addr, e.wdata});
        if (r_gnt && !m_we) rr_pending = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic        rr_mode;
    logic        router_wins;
    logic [15:0] exp_r, exp_h;
`ifdef ARB_ROUND_ROBIN_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    reset = 1'b1;
    r_cs = 1'b0; r_we = 1'b0; r_address = 8'h00; r_wdata = 8'h00;
    h_cs = 1'b0; h_we = 1'b0; h_address = 8'h00; h_wdata = 8'h00;

    // Reset with both ports requesting: nothing may be granted.
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
    @(negedge clk);
    check_output("reset_grants", {30'd0, r_gnt, h_gnt}, 32'd0);
    check_output("reset_mcs", {30'd0, m_cs, m_we}, 32'd0);
    check_output("reset_rvalid", {31'd0, h_rvalid}, 32'd0);
    check_output("reset_counts", {r_count, h_count}, 32'd0);

    // Router read of 0x05 right after reset.
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    expect_access(1'b1, 1'b0, 8'h05, 8'h00);
    rrd_q.push_back(8'hA5);
    @(negedge clk);
    check_output("r_gnt_same_cycle", {31'd0, r_gnt}, 32'd1);
    idle_cycle();
    @(negedge clk);
    check_output("router_read_no_hvalid", {31'd0, h_rvalid}, 32'd0);
    check_output("r_count_after_read", {16'd0, r_count}, 32'd1);

    // Host write of 0x3C to 0x80.
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h80, 8'h3C);
    expect_access(1'b0, 1'b1, 8'h80, 8'h3C);
    idle_cycle();
    @(negedge clk);
    check_output("write_no_hvalid", {31'd0, h_rvalid}, 32'd0);

    // Host read of 0x10: exactly one valid cycle carrying 0xEE.
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    expect_access(1'b0, 1'b0, 8'h10, 8'h00);
    hrd_q.push_back(8'hEE);
    idle_cycle();
    @(negedge clk);
    check_output("hvalid_one_cycle", {31'd0, h_rvalid}, 32'd1);
    idle_cycle();
    @(negedge clk);
    check_output("hvalid_dropped", {31'd0, h_rvalid}, 32'd0);

    // Host read back of the earlier write.
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00);
    expect_access(1'b0, 1'b0, 8'h80, 8'h00);
    hrd_q.push_back(8'h3C);
    idle_cycle();
    @(negedge clk);
    check_output("h_count_after_three", {16'd0, h_count}, 32'd3);

    // 64-cycle router burst with the host waiting the whole time.
    for (int i = 0; i < 64; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b1, 8'h80, 8'h3C);
      expect_access(1'b1, 1'b0, 8'(i), 8'h00);
      rrd_q.push_back(exp_mem(8'(i)));
      @(negedge clk);
      check_output($sformatf("burst_h_gnt_%0d", i), {31'd0, h_gnt}, 32'd0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h80, 8'h3C);
    expect_access(1'b0, 1'b1, 8'h80, 8'h3C);
    @(negedge clk);
    check_output("handover_h_gnt", {31'd0, h_gnt}, 32'd1);
    check_output("r_count_after_burst", {16'd0, r_count}, 32'd65);
    idle_cycle();

    // Four simultaneous single-cycle pulses from an unlocked state.
    exp_r = 16'd65;
    exp_h = 16'd4;
    for (int k = 0; k < 4; k++) begin
      router_wins = rr_mode ? (k % 2 == 0) : 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'h20 + k), 8'h00,
                     1'b1, 1'b0, 8'(8'h30 + k), 8'h00);
      if (router_wins) begin
        expect_access(1'b1, 1'b0, 8'(8'h20 + k), 8'h00);
        rrd_q.push_back(8'h00);
        exp_r++;
      end else begin
        expect_access(1'b0, 1'b0, 8'(8'h30 + k), 8'h00);
        hrd_q.push_back(8'h00);
        exp_h++;
      end
      idle_cycle();
    end
    @(negedge clk);
    check_output("counts_after_pulses", {r_count, h_count}, {exp_r, exp_h});

    // Reset in the middle of a router burst.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      expect_access(1'b1, 1'b0, 8'h05, 8'h00);
      rrd_q.push_back(8'hA5);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    check_output("midburst_reset_mcs", {31'd0, m_cs}, 32'd0);
    check_output("midburst_reset_grants", {30'd0, r_gnt, h_gnt}, 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    expect_access(1'b0, 1'b0, 8'h10, 8'h00);
    hrd_q.push_back(8'hEE);
    @(negedge clk);
    check_output("post_reset_h_gnt", {31'd0, h_gnt}, 32'd1);
    check_output("post_reset_counts", {r_count, h_count}, 32'd0);
    idle_cycle();
    idle_cycle();
    @(negedge clk);

    check_output("leftover_accesses", acc_q.size(), 32'd0);
    check_output("leftover_router_reads", rrd_q.size(), 32'd0);
    check_output("leftover_host_reads", hrd_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
